// File: rtl/conv_window_ctrl_if.sv
// Pixel-source stream between the feature-map source and the window controller.
// Handshake: a pixel transfers on every rising clk edge where src_valid and
// src_ready are both 1; src_data must be stable while src_valid is 1, and
// src_valid may drop at any time (gaps are legal).
interface conv_window_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;

  // Feature-map source side.
  modport master (
    output src_valid,
    output src_data,
    input  src_ready
  );

  // Window controller side.
  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Frame sequencer and 5x5 window assembler for the convolution front end.
// Feeds one feature map per start into an external LineBuffer, turns its
// 5-row column taps into a sliding 5x5 window and emits one window per legal
// position (no wrap across rows), tagged with its top-left row/column.
module conv_window_ctrl #(
  parameter int MAP_W  = 28,
  parameter int MAP_H  = 28,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  conv_window_ctrl_if.slave     pix,
  output logic [DATA_W-1:0]     lb_din,
  output logic                  lb_in_valid,
  input  logic [DATA_W-1:0]     lb_out1,
  input  logic [DATA_W-1:0]     lb_out2,
  input  logic [DATA_W-1:0]     lb_out3,
  input  logic [DATA_W-1:0]     lb_out4,
  input  logic [DATA_W-1:0]     lb_out5,
  input  logic                  lb_out_valid,
  output logic [25*DATA_W-1:0]  win_data,
  output logic                  win_valid,
  output logic [15:0]           win_row,
  output logic [15:0]           win_col,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int TOTAL = MAP_W * MAP_H;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(TOTAL - 1);
  localparam logic [15:0]   LAST_COL = 16'(MAP_W - 1);
  localparam logic [15:0]   LAST_ROW = 16'(MAP_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic [CW-1:0]     pix_cnt;
  logic [15:0]       col;
  logic [15:0]       row;
  logic              hs;
  logic              col_adv;
  logic              last_column;
  logic [DATA_W-1:0] taps [5];
  logic [DATA_W-1:0] win_q [5][5];

  // Source handshake passes straight through to the LineBuffer write port.
  assign hs          = pix.src_valid & ready_q;
  assign pix.src_ready = ready_q;
  assign lb_din      = pix.src_data;
  assign lb_in_valid = hs;

  // LineBuffer columns only count while a frame is in flight.
  assign col_adv     = lb_out_valid & ((state == FEED) | (state == DRAIN));

  // Row/column counters walk the whole column sequence, so the final column
  // of the map is exactly column count MAP_W*MAP_H - 4*MAP_W.
  assign last_column = (col == LAST_COL) & (row == LAST_ROW);

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state;

  // Tap order: lb_out1 is the oldest row and lands in the window's top row.
  always_comb begin
    taps[0] = lb_out1;
    taps[1] = lb_out2;
    taps[2] = lb_out3;
    taps[3] = lb_out4;
    taps[4] = lb_out5;
  end

  // Frame sequencer with registered src_ready/busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pix_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state   <= FEED;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            pix_cnt <= '0;
          end
        end
        FEED: begin
          if (hs) begin
            if (pix_cnt == LAST_PIX) begin
              state   <= DRAIN;
              ready_q <= 1'b0;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Leave on the edge that loads the final window so done lines up
          // with the last win_valid.
          if (col_adv && last_column) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Column position of the next LineBuffer column; the first column out of
  // the LineBuffer belongs to pixel 4*MAP_W, hence the row start of 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= 16'd4;
    end else if (col_adv) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // Sliding window: shift columns left and load the new column at c=4.
  // Columns 0..3 of a row still load (to refill the window) but never flag
  // a window, which is what stops wrap-around across rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win_q[r][c] <= '0;
        end
      end
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (col_adv) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][4] <= taps[r];
      end
      win_valid <= (col >= 16'd4);
      win_row   <= row - 16'd4;
      win_col   <= col - 16'd4;
    end else begin
      win_valid <= 1'b0;
    end
  end

  // Flatten the window: element (r,c) at bits [(r*5+c)*DATA_W +: DATA_W].
  always_comb begin
    win_data = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win_data[(r*5+c)*DATA_W +: DATA_W] = win_q[r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl on an 8x6 map with a behavioural LineBuffer.
// The driver pushes each expected window (cycle, row, col, data, done) when
// the pixel that completes it is handshaken; the monitor pops and compares.
module tb_conv_window_ctrl;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int DW    = 16;
  localparam int TOTAL = W * H;
  localparam int EW    = 32 + 1 + 16 + 16 + 25 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [DW-1:0] lb_din;
  logic lb_in_valid;
  logic [DW-1:0] lb_out1, lb_out2, lb_out3, lb_out4, lb_out5;
  logic lb_out_valid;
  logic [25*DW-1:0] win_data;
  logic win_valid;
  logic [15:0] win_row, win_col;
  logic busy, done;
  logic [1:0] dbg_state;

  conv_window_ctrl_if #(.DATA_W(DW)) pix ();

  conv_window_ctrl #(.MAP_W(W), .MAP_H(H), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix(pix),
    .lb_din(lb_din), .lb_in_valid(lb_in_valid),
    .lb_out1(lb_out1), .lb_out2(lb_out2), .lb_out3(lb_out3),
    .lb_out4(lb_out4), .lb_out5(lb_out5), .lb_out_valid(lb_out_valid),
    .win_data(win_data), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural LineBuffer ----------------
  // Write at the end of the handshake cycle, taps visible two cycles later.
  logic [DW-1:0] lb_mem [TOTAL];
  int lb_cnt;
  logic s1_v;
  logic [DW-1:0] s1_t [5];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_cnt <= 0;
      s1_v <= 1'b0;
      lb_out_valid <= 1'b0;
      lb_out1 <= '0; lb_out2 <= '0; lb_out3 <= '0; lb_out4 <= '0; lb_out5 <= '0;
    end else begin
      s1_v <= 1'b0;
      if (lb_in_valid) begin
        lb_mem[lb_cnt] <= lb_din;
        if (lb_cnt >= 4 * W) begin
          s1_v <= 1'b1;
          s1_t[4] <= lb_din;
          s1_t[3] <= lb_mem[lb_cnt - W];
          s1_t[2] <= lb_mem[lb_cnt - 2 * W];
          s1_t[1] <= lb_mem[lb_cnt - 3 * W];
          s1_t[0] <= lb_mem[lb_cnt - 4 * W];
        end
        lb_cnt <= (lb_cnt == TOTAL - 1) ? 0 : lb_cnt + 1;
      end
      lb_out_valid <= s1_v;
      lb_out1 <= s1_t[0]; lb_out2 <= s1_t[1]; lb_out3 <= s1_t[2];
      lb_out4 <= s1_t[3]; lb_out5 <= s1_t[4];
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int win_count = 0;
  int done_count = 0;

  task automatic chk(input string nm, input logic [25*DW-1:0] act, input logic [25*DW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [EW-1:0] make_exp(input int wr, input int wc, input int base,
                                             input bit dn, input int ecyc);
    logic [25*DW-1:0] d;
    d = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        d[(r*5+c)*DW +: DW] = DW'(base + (wr + r) * W + wc + c);
      end
    end
    return {32'(ecyc), dn, 16'(wr), 16'(wc), d};
  endfunction

  // Monitor: every presented window must match the head of the queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && win_valid) begin
      win_count++;
      if (done) done_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_window: row=%0d col=%0d with empty queue", win_row, win_col);
      end else begin
        e = exp_q.pop_front();
        chk("win_cycle", 400'(cyc), 400'(e[EW-1 -: 32]));
        chk("win_done",  400'(done), 400'(e[432]));
        chk("win_row",   400'(win_row), 400'(e[431:416]));
        chk("win_col",   400'(win_col), 400'(e[415:400]));
        chk("win_data",  win_data, e[399:0]);
      end
    end
    if (rst_n && done && !win_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_alone: done=1 without win_valid at cycle %0d", cyc);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks enter and leave one time unit after a rising edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    chk("idle_ready", 400'(pix.src_ready), 400'(0));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("feed_ready", 400'(pix.src_ready), 400'(1));
    chk("feed_busy",  400'(busy), 400'(1));
    @(posedge clk); #1;
  endtask

  task automatic send_pixel(input logic [DW-1:0] v, output bit ok, output int hs_cyc);
    ok = 1'b0;
    hs_cyc = 0;
    pix.src_valid = 1'b1;
    pix.src_data = v;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (pix.src_ready) begin
        ok = 1'b1;
        hs_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout: pixel %0d never accepted", v);
    end
  endtask

  task automatic run_frame(input int base, input bit gaps, input bit poke_start);
    int w0, d0, hs_cyc, t_last;
    bit ok;
    w0 = win_count;
    d0 = done_count;
    t_last = 0;
    do_start();
    for (int p = 0; p < TOTAL; p++) begin
      if (gaps) begin
        while ($urandom_range(0, 99) < 40) begin
          pix.src_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      start = (poke_start && p == 10);
      send_pixel(DW'(base + p), ok, hs_cyc);
      start = 1'b0;
      if (!ok) begin
        pix.src_valid = 1'b0;
        return;
      end
      if (p / W >= 4 && p % W >= 4)
        exp_q.push_back(make_exp(p / W - 4, p % W - 4, base, p == TOTAL - 1, hs_cyc + 3));
      t_last = hs_cyc;
    end
    pix.src_valid = 1'b0;
    if (poke_start) begin
      // One cycle after the last handshake the sequencer is draining.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 20 && cyc < t_last + 3; k++) @(negedge clk);
    chk("end_cycle", 400'(cyc), 400'(t_last + 3));
    chk("end_done",  400'(done), 400'(1));
    chk("end_busy",  400'(busy), 400'(1));
    @(negedge clk);
    chk("idle_busy",  400'(busy), 400'(0));
    chk("idle_state", 400'(dbg_state), 400'(0));
    repeat (3) @(negedge clk);
    chk("no_queued_start", 400'(busy), 400'(0));
    chk("frame_windows", 400'(win_count - w0), 400'((H - 4) * (W - 4)));
    chk("frame_dones",   400'(done_count - d0), 400'(1));
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"},  400'(pix.src_ready), 400'(0));
    chk({tag, "_wvalid"}, 400'(win_valid), 400'(0));
    chk({tag, "_wdata"},  win_data, 400'(0));
    chk({tag, "_wrow"},   400'(win_row), 400'(0));
    chk({tag, "_wcol"},   400'(win_col), 400'(0));
    chk({tag, "_busy"},   400'(busy), 400'(0));
    chk({tag, "_done"},   400'(done), 400'(0));
    chk({tag, "_state"},  400'(dbg_state), 400'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int hs_cyc;
    pix.src_valid = 1'b0;
    pix.src_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 1'b0, 1'b0);     // continuous
    run_frame(0, 1'b1, 1'b0);     // random source gaps
    run_frame(100, 1'b0, 1'b1);   // start pokes ignored, offset pixel values

    // Reset mid-frame after pixel 20, then a clean frame.
    do_start();
    for (int p = 0; p <= 20; p++) send_pixel(DW'(p), ok, hs_cyc);
    pix.src_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    chk("queue_drained", 400'(exp_q.size()), 400'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
